// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard and forwarding controller that sits beside the ID/EX stage of the
// pipelined RISC-V core.
//   * Per-operand forwarding selects for EX:
//       00 regfile, 10 EX/MEM, 01 MEM/WB, 11 late write-back bypass.
//   * Load-use bubble generation (stall PC and IF/ID, flush ID/EX) for one cycle.
//   * Whole-pipeline freeze while a load in MEM waits on mem_ready.
//   * Sticky freeze watchdog and a saturating stall-cycle counter.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int RF_BYPASS  = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                           clk,
  input  logic                           arst,
  // Instruction in EX
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  id_ex_rs,
  input  logic [REG_ADDR_W-1:0]          id_ex_rd,
  input  logic                           id_ex_memread,
  // Instruction in ID
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  if_id_rs,
  input  logic [NUM_SRC-1:0]             if_id_rs_valid,
  // Instructions in MEM and WB
  input  logic [REG_ADDR_W-1:0]          ex_mem_rd,
  input  logic [REG_ADDR_W-1:0]          mem_wb_rd,
  input  logic                           ex_mem_regwrite,
  input  logic                           mem_wb_regwrite,
  input  logic                           ex_mem_memread,
  // Data memory handshake
  input  logic                           mem_ready,
  // Controls
  output logic [2*NUM_SRC-1:0]           fwd_sel,
  output logic                           stall_pc,
  output logic                           stall_ifid,
  output logic                           flush_idex,
  output logic                           freeze,
  output logic                           mem_timeout,
  output logic [15:0]                    stall_cycles
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUBBLE  = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  localparam logic [1:0] SEL_RF     = 2'b00;
  localparam logic [1:0] SEL_EXMEM  = 2'b10;
  localparam logic [1:0] SEL_MEMWB  = 2'b01;
  localparam logic [1:0] SEL_LATEWB = 2'b11;

  // Watchdog compare value widened by one bit so that cnt+1 never wraps.
  localparam logic [8:0] TIMEOUT_CMP = 9'(TIMEOUT);
  localparam logic       BYPASS_EN   = (RF_BYPASS != 0);

  // ---------------------------------------------------------------------------
  // Registers and internal nets
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  state_t                  w_next_state;

  logic [REG_ADDR_W-1:0]   r_late_rd;
  logic                    r_late_we;

  logic [7:0]              r_wd_cnt;
  logic [8:0]              w_wd_cnt_inc;
  logic                    r_mem_timeout;

  logic [15:0]             r_stall_cycles;

  logic                    w_mem_busy;
  logic [NUM_SRC-1:0]      w_lu_hit;
  logic                    w_load_use;
  logic                    w_bubble;
  logic                    w_freeze;

  // ---------------------------------------------------------------------------
  // Hazard detection terms
  // ---------------------------------------------------------------------------
  assign w_mem_busy = ex_mem_memread & ~mem_ready;

  // Per-operand match of an ID source against the load destination in EX.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_load_use
    logic [REG_ADDR_W-1:0] w_rs;
    assign w_rs        = if_id_rs[k*REG_ADDR_W +: REG_ADDR_W];
    assign w_lu_hit[k] = if_id_rs_valid[k] & (w_rs == id_ex_rd);
  end

  // x0 is never a real producer, so a load into x0 can never cause a hazard.
  assign w_load_use = id_ex_memread & (id_ex_rd != '0) & (|w_lu_hit);

  // ---------------------------------------------------------------------------
  // Forwarding selects (purely combinational, per operand)
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
    logic [REG_ADDR_W-1:0] w_rs;
    logic                  w_hit_exmem;
    logic                  w_hit_memwb;
    logic                  w_hit_late;
    logic [1:0]            w_sel;

    assign w_rs        = id_ex_rs[k*REG_ADDR_W +: REG_ADDR_W];
    assign w_hit_exmem = ex_mem_regwrite & (ex_mem_rd != '0) & (ex_mem_rd == w_rs);
    assign w_hit_memwb = mem_wb_regwrite & (mem_wb_rd != '0) & (mem_wb_rd == w_rs);
    assign w_hit_late  = BYPASS_EN & r_late_we & (r_late_rd != '0) & (r_late_rd == w_rs);

    // Priority select: youngest producer wins; reset forces the regfile path.
    always_comb begin
      // NOTE: a default assignment before any branching guarantees every path
      // drives w_sel, so no latch can be inferred.
      w_sel = SEL_RF;
      if (arst) begin
        w_sel = SEL_RF;
      end else if (w_hit_exmem) begin
        w_sel = SEL_EXMEM;
      end else if (w_hit_memwb) begin
        w_sel = SEL_MEMWB;
      end else if (w_hit_late) begin
        w_sel = SEL_LATEWB;
      end
    end

    assign fwd_sel[2*k +: 2] = w_sel;
  end

  // ---------------------------------------------------------------------------
  // Hazard FSM: state register
  // ---------------------------------------------------------------------------
  // State register with asynchronous return to IDLE.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard FSM: next-state logic
  // ---------------------------------------------------------------------------
  // Memory stalls take precedence over load-use; BUBBLE always leaves after one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_busy) begin
          w_next_state = ST_MEMWAIT;
        end else if (w_load_use) begin
          w_next_state = ST_BUBBLE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUBBLE: begin
        if (w_mem_busy) begin
          w_next_state = ST_MEMWAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_MEMWAIT: begin
        if (w_mem_busy) begin
          w_next_state = ST_MEMWAIT;
        end else if (w_load_use) begin
          w_next_state = ST_BUBBLE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hazard FSM: output logic
  // ---------------------------------------------------------------------------
  // Bubble only when not frozen and load-use is not masked by a bubble just issued.
  always_comb begin
    w_bubble = 1'b0;
    case (r_state)
      ST_IDLE:    w_bubble = ~w_mem_busy & w_load_use;
      ST_BUBBLE:  w_bubble = 1'b0;
      ST_MEMWAIT: w_bubble = ~w_mem_busy & w_load_use;
      default:    w_bubble = 1'b0;
    endcase
  end

  assign w_freeze   = w_mem_busy & ~arst;
  assign freeze     = w_freeze;
  assign stall_pc   = w_bubble & ~arst;
  assign stall_ifid = w_bubble & ~arst;
  assign flush_idex = w_bubble & ~arst;

  // ---------------------------------------------------------------------------
  // Late write-back register
  // ---------------------------------------------------------------------------
  // Remember last cycle's WB destination so a same-cycle regfile write/read
  // can still be bypassed; held while the pipeline is frozen.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_late_rd <= '0;
      r_late_we <= 1'b0;
    end else if (!w_freeze) begin
      r_late_rd <= mem_wb_rd;
      r_late_we <= mem_wb_regwrite;
    end
  end

  // ---------------------------------------------------------------------------
  // Freeze watchdog
  // ---------------------------------------------------------------------------
  assign w_wd_cnt_inc = {1'b0, r_wd_cnt} + 9'd1;

  // Count consecutive frozen cycles; flag sticks once the run reaches TIMEOUT.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wd_cnt      <= '0;
      r_mem_timeout <= 1'b0;
    end else if (w_freeze) begin
      if (r_wd_cnt != 8'hFF) begin
        r_wd_cnt <= w_wd_cnt_inc[7:0];
      end
      if (w_wd_cnt_inc == TIMEOUT_CMP) begin
        r_mem_timeout <= 1'b1;
      end
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign mem_timeout = r_mem_timeout;

  // ---------------------------------------------------------------------------
  // Stall-cycle statistics
  // ---------------------------------------------------------------------------
  // Saturating count of cycles in which the PC was held by a bubble or a freeze.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_stall_cycles <= '0;
    end else if ((w_bubble | w_freeze) && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Two instances share all inputs: one with the late bypass enabled, one with it
// disabled, both with a short watchdog timeout. Directed vectors and sequences
// cover the documented corner cases; a randomized phase compares against a
// cycle-level reference model built from the hazard rules.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              arst;
  logic [NS*AW-1:0]  id_ex_rs;
  logic [AW-1:0]     id_ex_rd;
  logic              id_ex_memread;
  logic [NS*AW-1:0]  if_id_rs;
  logic [NS-1:0]     if_id_rs_valid;
  logic [AW-1:0]     ex_mem_rd;
  logic [AW-1:0]     mem_wb_rd;
  logic              ex_mem_regwrite;
  logic              mem_wb_regwrite;
  logic              ex_mem_memread;
  logic              mem_ready;

  logic [2*NS-1:0]   fwd_b,        fwd_n;
  logic              stall_pc_b,   stall_pc_n;
  logic              stall_ifid_b, stall_ifid_n;
  logic              flush_b,      flush_n;
  logic              freeze_b,     freeze_n;
  logic              timeout_b,    timeout_n;
  logic [15:0]       cycles_b,     cycles_n;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_ADDR_W(AW), .NUM_SRC(NS), .RF_BYPASS(1), .TIMEOUT(TO)) dut_b (
    .clk(clk), .arst(arst),
    .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
    .if_id_rs(if_id_rs), .if_id_rs_valid(if_id_rs_valid),
    .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
    .ex_mem_memread(ex_mem_memread), .mem_ready(mem_ready),
    .fwd_sel(fwd_b), .stall_pc(stall_pc_b), .stall_ifid(stall_ifid_b),
    .flush_idex(flush_b), .freeze(freeze_b), .mem_timeout(timeout_b),
    .stall_cycles(cycles_b)
  );

  hazard_forward_unit #(.REG_ADDR_W(AW), .NUM_SRC(NS), .RF_BYPASS(0), .TIMEOUT(TO)) dut_n (
    .clk(clk), .arst(arst),
    .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
    .if_id_rs(if_id_rs), .if_id_rs_valid(if_id_rs_valid),
    .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
    .ex_mem_memread(ex_mem_memread), .mem_ready(mem_ready),
    .fwd_sel(fwd_n), .stall_pc(stall_pc_n), .stall_ifid(stall_ifid_n),
    .flush_idex(flush_n), .freeze(freeze_n), .mem_timeout(timeout_n),
    .stall_cycles(cycles_n)
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_ex_rs        = '0;
    id_ex_rd        = '0;
    id_ex_memread   = 1'b0;
    if_id_rs        = '0;
    if_id_rs_valid  = '0;
    ex_mem_rd       = '0;
    mem_wb_rd       = '0;
    ex_mem_regwrite = 1'b0;
    mem_wb_regwrite = 1'b0;
    ex_mem_memread  = 1'b0;
    mem_ready       = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick();
    arst = 1'b0;
  endtask

  task automatic check_bubble(input string name, input logic exp);
    check({name, "_stall_pc"},   {31'd0, stall_pc_b},   {31'd0, exp});
    check({name, "_stall_ifid"}, {31'd0, stall_ifid_b}, {31'd0, exp});
    check({name, "_flush_idex"}, {31'd0, flush_b},      {31'd0, exp});
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (cycle level, derived from the hazard rules)
  // ---------------------------------------------------------------------------
  logic [AW-1:0] m_late_rd;
  logic          m_late_we;
  bit            m_prev_bubble;   // a bubble issued last cycle masks load-use now
  int            m_run;           // consecutive frozen cycles so far
  bit            m_timeout;
  int            m_stalls;

  task automatic model_reset();
    m_late_rd     = '0;
    m_late_we     = 1'b0;
    m_prev_bubble = 1'b0;
    m_run         = 0;
    m_timeout     = 1'b0;
    m_stalls      = 0;
  endtask

  function automatic logic [1:0] model_sel(input logic [AW-1:0] rs, input bit bypass);
    if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == rs) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs) return 2'b01;
    if (bypass && m_late_we && m_late_rd != 0 && m_late_rd == rs) return 2'b11;
    return 2'b00;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed forwarding vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          exw;
    logic [AW-1:0] exrd;
    logic          wbw;
    logic [AW-1:0] wbrd;
    logic [AW-1:0] rs0;
    logic [AW-1:0] rs1;
    logic [3:0]    exp;
  } fvec_t;

  fvec_t vecs[8];

  initial begin
    logic [3:0] exp_b, exp_n;
    bit         busy, lu, bub;

    vecs[0] = '{1'b1, 5'd5,  1'b1, 5'd5,  5'd5,  5'd5,  4'b1010};
    vecs[1] = '{1'b1, 5'd0,  1'b1, 5'd5,  5'd5,  5'd5,  4'b0101};
    vecs[2] = '{1'b1, 5'd3,  1'b1, 5'd4,  5'd3,  5'd4,  4'b0110};
    vecs[3] = '{1'b0, 5'd3,  1'b1, 5'd3,  5'd3,  5'd2,  4'b0001};
    vecs[4] = '{1'b1, 5'd7,  1'b0, 5'd7,  5'd1,  5'd7,  4'b1000};
    vecs[5] = '{1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  4'b0000};
    vecs[6] = '{1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0,  4'b0000};
    vecs[7] = '{1'b1, 5'd31, 1'b1, 5'd30, 5'd30, 5'd31, 4'b1001};

    // ---- reset: all combinational outputs forced low despite live hazards ----
    arst = 1'b1;
    clear_inputs();
    ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5; id_ex_rs = {5'd5, 5'd5};
    ex_mem_memread  = 1'b1; mem_ready = 1'b0;
    #2;
    check("rst_fwd_sel",      {28'd0, fwd_b},      32'd0);
    check("rst_freeze",       {31'd0, freeze_b},   32'd0);
    check_bubble("rst", 1'b0);
    check("rst_mem_timeout",  {31'd0, timeout_b},  32'd0);
    check("rst_stall_cycles", {16'd0, cycles_b},   32'd0);
    clear_inputs();
    tick();
    arst = 1'b0;

    // ---- forwarding priority vectors (late reg mirrors MEM/WB after each edge) ----
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      ex_mem_regwrite = vecs[i].exw;
      ex_mem_rd       = vecs[i].exrd;
      mem_wb_regwrite = vecs[i].wbw;
      mem_wb_rd       = vecs[i].wbrd;
      id_ex_rs        = {vecs[i].rs1, vecs[i].rs0};
      tick();
      check($sformatf("vec%0d_fwd_byp", i),   {28'd0, fwd_b}, {28'd0, vecs[i].exp});
      check($sformatf("vec%0d_fwd_nobyp", i), {28'd0, fwd_n}, {28'd0, vecs[i].exp});
    end

    // ---- late write-back bypass: WB writes x9 in cycle N, EX reads x9 in N+1 ----
    clear_inputs();
    tick();
    mem_wb_rd = 5'd9; mem_wb_regwrite = 1'b1;
    tick();
    mem_wb_rd = 5'd0; mem_wb_regwrite = 1'b0;
    id_ex_rs  = {5'd0, 5'd9};
    #1;
    check("late_fwd_byp",   {28'd0, fwd_b}, 32'b0011);
    check("late_fwd_nobyp", {28'd0, fwd_n}, 32'b0000);
    tick();
    check("late_expired", {28'd0, fwd_b}, 32'b0000);

    // ---- load-use bubble, then the load sits in MEM and forwards 10 ----
    clear_inputs();
    id_ex_memread = 1'b1; id_ex_rd = 5'd7;
    if_id_rs = {5'd0, 5'd7}; if_id_rs_valid = 2'b01;
    #1;
    check_bubble("lu_first", 1'b1);
    tick();
    clear_inputs();
    ex_mem_memread = 1'b1; ex_mem_rd = 5'd7; ex_mem_regwrite = 1'b1; mem_ready = 1'b1;
    id_ex_rs = {5'd0, 5'd7};
    #1;
    check_bubble("lu_after", 1'b0);
    check("lu_consumer_fwd", {28'd0, fwd_b}, 32'b0010);
    tick();

    // ---- back-to-back: load-use held two cycles gives one bubble ----
    clear_inputs();
    id_ex_memread = 1'b1; id_ex_rd = 5'd7;
    if_id_rs = {5'd0, 5'd7}; if_id_rs_valid = 2'b01;
    #1;
    check_bubble("b2b_c0", 1'b1);
    tick();
    check_bubble("b2b_c1_masked", 1'b0);
    clear_inputs();
    tick();

    // ---- operand not really read, operand 1 path, load into x0 ----
    id_ex_memread = 1'b1; id_ex_rd = 5'd7;
    if_id_rs = {5'd0, 5'd7}; if_id_rs_valid = 2'b00;
    #1;
    check_bubble("lu_invalid", 1'b0);
    if_id_rs = {5'd7, 5'd3}; if_id_rs_valid = 2'b10;
    #1;
    check_bubble("lu_rs1", 1'b1);
    tick();
    clear_inputs();
    tick();
    id_ex_memread = 1'b1; id_ex_rd = 5'd0;
    if_id_rs = {5'd0, 5'd0}; if_id_rs_valid = 2'b11;
    #1;
    check_bubble("lu_x0", 1'b0);

    // ---- freeze for 3 cycles: late register holds, bubble suppressed ----
    clear_inputs();
    do_reset();
    mem_wb_rd = 5'd12; mem_wb_regwrite = 1'b1;
    tick();
    check("frz_pre_cycles", {16'd0, cycles_b}, 32'd0);
    ex_mem_memread = 1'b1; mem_ready = 1'b0; ex_mem_rd = 5'd20; ex_mem_regwrite = 1'b1;
    mem_wb_rd = 5'd13;
    id_ex_rs = {5'd0, 5'd12};
    id_ex_memread = 1'b1; id_ex_rd = 5'd12;
    if_id_rs = {5'd0, 5'd12}; if_id_rs_valid = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("frz%0d_freeze", c), {31'd0, freeze_b}, 32'd1);
      check_bubble($sformatf("frz%0d", c), 1'b0);
      check($sformatf("frz%0d_late_held", c), {28'd0, fwd_b}, 32'b0011);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("frz_exit_freeze",   {31'd0, freeze_b},  32'd0);
    check_bubble("frz_exit_lu", 1'b1);
    check("frz_exit_cycles",   {16'd0, cycles_b},  32'd3);
    check("frz_exit_late",     {28'd0, fwd_b},     32'b0011);
    tick();
    check("frz_post_cycles",   {16'd0, cycles_b},  32'd4);
    check("frz_post_late",     {28'd0, fwd_b},     32'b0000);
    check_bubble("frz_post_masked", 1'b0);
    check("frz_no_timeout",    {31'd0, timeout_b}, 32'd0);
    clear_inputs();
    tick();

    // ---- watchdog: sets after the TO-th frozen cycle and sticks ----
    do_reset();
    ex_mem_memread = 1'b1; mem_ready = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      tick();
      check($sformatf("wd_after_%0d", c), {31'd0, timeout_b}, {31'd0, (c >= TO)});
    end
    mem_ready = 1'b1;
    tick();
    tick();
    check("wd_sticky",        {31'd0, timeout_b}, 32'd1);
    check("wd_freeze_off",    {31'd0, freeze_b},  32'd0);

    // ---- reset in the middle of a memory wait ----
    mem_ready = 1'b0;
    ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5; id_ex_rs = {5'd5, 5'd5};
    tick();
    check("mw_freeze", {31'd0, freeze_b}, 32'd1);
    #2;
    arst = 1'b1;
    #1;
    check("mw_rst_freeze",  {31'd0, freeze_b},  32'd0);
    check("mw_rst_fwd",     {28'd0, fwd_b},     32'd0);
    check("mw_rst_timeout", {31'd0, timeout_b}, 32'd0);
    check("mw_rst_cycles",  {16'd0, cycles_b},  32'd0);
    mem_ready = 1'b1;
    id_ex_memread = 1'b1; id_ex_rd = 5'd7;
    if_id_rs = {5'd0, 5'd7}; if_id_rs_valid = 2'b01;
    #1;
    check_bubble("mw_rst", 1'b0);
    tick();
    arst = 1'b0;
    #1;
    check_bubble("mw_idle_after_rst", 1'b1);
    clear_inputs();
    tick();

    // ---- randomized phase against the reference model ----
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      id_ex_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_ex_rd        = 5'($urandom_range(0, 3));
      id_ex_memread   = ($urandom_range(0, 2) == 0);
      if_id_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      if_id_rs_valid  = 2'($urandom_range(0, 3));
      ex_mem_rd       = 5'($urandom_range(0, 3));
      mem_wb_rd       = 5'($urandom_range(0, 3));
      ex_mem_regwrite = ($urandom_range(0, 1) == 1);
      mem_wb_regwrite = ($urandom_range(0, 1) == 1);
      ex_mem_memread  = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 4) != 0);
      #1;

      busy  = ex_mem_memread && !mem_ready;
      lu    = id_ex_memread && (id_ex_rd != 0) &&
              ((if_id_rs_valid[0] && if_id_rs[AW-1:0]    == id_ex_rd) ||
               (if_id_rs_valid[1] && if_id_rs[2*AW-1:AW] == id_ex_rd));
      bub   = !busy && lu && !m_prev_bubble;
      exp_b = {model_sel(id_ex_rs[2*AW-1:AW], 1'b1), model_sel(id_ex_rs[AW-1:0], 1'b1)};
      exp_n = {model_sel(id_ex_rs[2*AW-1:AW], 1'b0), model_sel(id_ex_rs[AW-1:0], 1'b0)};

      check("rnd_fwd_byp",    {28'd0, fwd_b},     {28'd0, exp_b});
      check("rnd_fwd_nobyp",  {28'd0, fwd_n},     {28'd0, exp_n});
      check("rnd_freeze",     {31'd0, freeze_b},  {31'd0, busy});
      check_bubble("rnd", bub);
      check("rnd_timeout",    {31'd0, timeout_b}, {31'd0, m_timeout});
      check("rnd_cycles",     {16'd0, cycles_b},  m_stalls);

      if (!busy) begin
        m_late_rd = mem_wb_rd;
        m_late_we = mem_wb_regwrite;
      end
      m_prev_bubble = bub;
      m_run = busy ? m_run + 1 : 0;
      if (m_run >= TO) m_timeout = 1'b1;
      if ((bub || busy) && m_stalls < 65535) m_stalls++;

      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
